axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Single-port AXI3 slave memory model that sits directly downstream of the core's AXI master bridge and consumes its ar/aw/w channels.
- Returns r and b responses with the originating ID, so IFU fetches and LSU accesses are tagged correctly.
- Serves single-beat 32-bit accesses from an internal word array, with a configurable read latency.
- Used for simulation, and as the FPGA on-chip RAM behind the core.

Parameters:
- MEM_AW, 12, word-address width; depth = 2^MEM_AW 32-bit words.
- BASE_ADDR, 32'h1c00_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR handshake to rvalid (minimum 1, maximum 15).

Ports:
- aclk in 1: clock.
- areset in 1: synchronous reset, active-high.
- arid in 4, araddr in 32, arlen in 8, arsize in 3, arvalid in 1: read address channel.
- arready out 1: read address accept.
- rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1: read data channel.
- rready in 1: read data accept.
- awid in 4, awaddr in 32, awlen in 8, awsize in 3, awvalid in 1: write address channel.
- awready out 1: write address accept.
- wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1: write data channel.
- wready out 1: write data accept.
- bid out 4, bresp out 2, bvalid out 1: write response channel.
- bready in 1: write response accept.

Behaviour:
- Reset values: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rid/rdata/rresp/bid/bresp=0, rlast=0. Memory contents are not reset.
- Read FSM states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On arvalid, latch arid, araddr, and the error flag, load the latency counter with RD_LAT-1, and go to R_WAIT.
  - R_WAIT: arready=0. Count down. At 0, sample the memory, raise rvalid with rlast=1, and go to R_RESP.
  - R_RESP: hold rid, rdata, rresp until rvalid&rready, then return to R_IDLE. arready goes high again the cycle after the handshake.
  - Latency: RD_LAT=1 gives rvalid exactly one cycle after the AR handshake.
- Only one read is outstanding at a time.
- Write path, independent of the read path:
  - awready=1 while the AW slot is empty; wready=1 while the W slot is empty.
  - AW and W may handshake in the same cycle, or in either order.
  - Once both slots are full, commit to memory in the next cycle, byte-enabled by wstrb. bvalid rises in that commit cycle with bid=latched awid.
  - Hold bvalid until bready. Both slots clear on the B handshake; awready/wready go high the following cycle.
  - wid and wlast are ignored.
- Address and error rules:
  - Word index = (addr - BASE_ADDR)[MEM_AW+1:2]. Low two address bits are ignored.
  - An access is in range when BASE_ADDR <= addr < BASE_ADDR + 4*2^MEM_AW.
  - Out-of-range, or len!=0, or size!=2: resp=2'b10 (SLVERR). Reads return rdata=0; writes leave memory unchanged. Handshakes are otherwise normal.
  - Otherwise resp=2'b00.
- Simultaneous read sample and write commit to the same word: the read returns the newly written bytes (write-first bypass per byte lane).
- A master that keeps rready=1 and bready=1 constantly completes each access without stalling the B/R channels.
- areset mid-transaction: all in-flight state is dropped, the FSMs return to idle, and no response is issued for the dropped access.

Optional Feature:
- Macro AXI_SRAM_RAND_STALL_EN.
- When defined: a 16-bit LFSR (seed 16'hACE1 on reset, advancing every cycle) gates the ready outputs. arready, awready, and wready are additionally ANDed with LFSR bits 0, 1, and 2 respectively. This stresses the master's valid-hold logic.
- When undefined: the ready outputs are exactly as in Behaviour and no LFSR is built.

Decomposition:
- Shared package holds:
  - ID constants IFU_ID=4'b0000 and LSU_ID=4'b0001.
  - Response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - SIZE_WORD=3'h2.
- Sub-module axi_sram_mem: synchronous word array with one read port and one byte-enabled write port plus the write-first bypass, parameterised by MEM_AW.
- The FSMs, address decode, and channel registers stay in the top level.

Test Plan:
- Read latency (RD_LAT=1): preload word 4 with 32'hDEADBEEF; AR with arid=0, araddr=BASE+16 -> rvalid exactly one cycle after the AR handshake, rdata=32'hDEADBEEF, rid=0, rresp=0, rlast=1.
- Partial write: write 32'h11223344 with wstrb=4'b1111, then 32'hAABBCCDD with wstrb=4'b0101, both with AW and W in the same cycle, awid=1 -> each bid=1, bresp=0; a subsequent read returns 32'h11BB33DD.
- Channel ordering: W arrives 3 cycles before AW -> wready drops after the W handshake and the commit waits for AW; with AW first, symmetric behaviour. A single B is issued in both cases.
- Backpressure: hold rready=0 for 5 cycles -> rvalid, rdata, rid stay stable and arready=0 throughout; the next AR is accepted the cycle after the R handshake.
- Errors: read at BASE+4*2^MEM_AW -> rresp=2'b10, rdata=0; write with arsize/awsize=0 -> bresp=2'b10 and memory unchanged.
- Reset mid-operation: assert areset during R_WAIT -> no rvalid; after release, arready=1 and a fresh read completes normally. With AXI_SRAM_RAND_STALL_EN, run 1000 random accesses against a scoreboard -> zero mismatches.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - shared constants, types and helpers for the AXI3 SRAM slave
//
// Purpose : ID and response codes, the read FSM state type, write-slot records
//           and the LFSR step used by the optional random-stall build
//           (AXI_SRAM_RAND_STALL_EN).
// Ports   : none (package)

package axi_sram_slave_pkg;

    localparam logic [3:0]  IFU_ID      = 4'b0000;
    localparam logic [3:0]  LSU_ID      = 4'b0001;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [2:0]  SIZE_WORD   = 3'h2;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    // Write-address slot: everything needed to decode the target and error at commit time.
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } aw_slot_t;

    // Write-data slot.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_slot_t;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AXI3 single-beat channel bundle between master bridge and SRAM slave
//
// Purpose : groups the ar/r/aw/w/b channel signals.
// Ports   : modport master drives ar*/aw*/w*/rready/bready;
//           modport slave drives arready/r*/awready/wready/b*.

interface axi_sram_slave_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_sram_mem.sv
// rtl/axi_sram_mem.sv - synchronous 32-bit word array, one read port, one byte-enabled write port
//
// Purpose : storage for the SRAM slave. A read and a write to the same word on
//           the same edge return the newly written bytes (write-first per lane).
// Ports   : clk, rst        - clock, synchronous active-high reset (read register only)
//           rd_en, rd_idx   - read request, word index; rd_data valid the cycle after
//           we, wr_idx, wr_data, wr_strb - byte-enabled write

module axi_sram_mem #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [MEM_AW-1:0] rd_idx,
    output logic [31:0]       rd_data,
    input  logic              we,
    input  logic [MEM_AW-1:0] wr_idx,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] raw_q;
    logic [31:0] byp_data_q;
    logic [3:0]  byp_mask_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // The array read stays a plain registered read; colliding write lanes are
    // captured alongside and merged on the way out.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q      <= '0;
            byp_data_q <= '0;
            byp_mask_q <= '0;
        end else if (rd_en) begin
            raw_q      <= mem_q[rd_idx];
            byp_data_q <= wr_data;
            byp_mask_q <= (we && (wr_idx == rd_idx)) ? wr_strb : 4'b0000;
        end
    end

    always_comb begin
        rd_data = raw_q;
        for (int b = 0; b < 4; b++) begin
            if (byp_mask_q[b]) begin
                rd_data[8*b +: 8] = byp_data_q[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-port AXI3 slave memory, single-beat 32-bit accesses
//
// Purpose : serves one outstanding read (latency RD_LAT) and one write at a
//           time from an internal word array; responses carry the request ID.
//           Optional macro AXI_SRAM_RAND_STALL_EN gates arready/awready/wready
//           with LFSR bits 0/1/2.
// Ports   : aclk   - clock
//           areset - synchronous reset, active-high
//           bus    - axi_sram_slave_if.slave (ar/r/aw/w/b channels)

module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
    parameter int          RD_LAT    = 1
) (
    input  logic            aclk,
    input  logic            areset,
    axi_sram_slave_if.slave bus
);

    // Offset from the base wraps for addresses below it, so one unsigned
    // compare covers both ends of the window.
    function automatic logic acc_err(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return ((off >> (MEM_AW + 2)) != 32'd0) || (len != 8'd0) || (size != SIZE_WORD);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return MEM_AW'(off >> 2);
    endfunction

    logic unused_w;
    assign unused_w = ^{bus.wid, bus.wlast};

    // ------------------------------------------------------------------
    // Ready gating
    // ------------------------------------------------------------------
    logic ar_gate, aw_gate, w_gate;

`ifdef AXI_SRAM_RAND_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr16_next(lfsr_q);
        end
    end

    assign ar_gate = lfsr_q[0];
    assign aw_gate = lfsr_q[1];
    assign w_gate  = lfsr_q[2];
`else
    assign ar_gate = 1'b1;
    assign aw_gate = 1'b1;
    assign w_gate  = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e         r_state_q;
    logic              arready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic [3:0]        rid_q;
    logic [1:0]        rresp_q;
    logic              r_err_q;
    logic [MEM_AW-1:0] r_idx_q;
    logic [3:0]        r_cnt_q;
    logic [31:0]       mem_rdata;
    logic              ar_hs;
    logic              r_sample;

    assign bus.arready = arready_q & ar_gate;
    assign ar_hs       = bus.arvalid & bus.arready;
    assign r_sample    = (r_state_q == R_WAIT) && (r_cnt_q == 4'd0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            r_err_q   <= 1'b0;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rid_q     <= bus.arid;
                        r_idx_q   <= word_idx(bus.araddr);
                        r_err_q   <= acc_err(bus.araddr, bus.arlen, bus.arsize);
                        r_cnt_q   <= 4'(RD_LAT - 1);
                        r_state_q <= R_WAIT;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q == 4'd0) begin
                        rvalid_q  <= 1'b1;
                        rlast_q   <= 1'b1;
                        rresp_q   <= r_err_q ? RESP_SLVERR : RESP_OKAY;
                        r_state_q <= R_RESP;
                    end else begin
                        r_cnt_q <= r_cnt_q - 4'd1;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        // Re-open AR directly so the next address lands the cycle after R.
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rlast  = rlast_q;
    assign bus.rid    = rid_q;
    assign bus.rresp  = rresp_q;
    // Error reads never touch the array; the held flag forces zero data.
    assign bus.rdata  = r_err_q ? 32'd0 : mem_rdata;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic     aw_full_q, aw_full_d;
    logic     w_full_q,  w_full_d;
    aw_slot_t aw_slot_q, aw_slot_d;
    w_slot_t  w_slot_q,  w_slot_d;
    logic     awready_q, awready_d;
    logic     wready_q,  wready_d;
    logic     bvalid_q,  bvalid_d;
    logic [3:0] bid_q,   bid_d;
    logic [1:0] bresp_q, bresp_d;
    logic     aw_hs, w_hs, b_hs, commit, wr_err, mem_we;

    assign bus.awready = awready_q & aw_gate;
    assign bus.wready  = wready_q & w_gate;
    assign aw_hs       = bus.awvalid & bus.awready;
    assign w_hs        = bus.wvalid & bus.wready;
    assign b_hs        = bvalid_q & bus.bready;
    // bvalid doubles as the "already committed" marker for the current pair.
    assign commit      = aw_full_q & w_full_q & ~bvalid_q;
    assign wr_err      = acc_err(aw_slot_q.addr, aw_slot_q.len, aw_slot_q.size);
    assign mem_we      = commit & ~wr_err;

    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        aw_slot_d = aw_slot_q;
        w_slot_d  = w_slot_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_slot_d = '{id: bus.awid, addr: bus.awaddr, len: bus.awlen, size: bus.awsize};
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_slot_d = '{data: bus.wdata, strb: bus.wstrb};
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bid_d    = aw_slot_q.id;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end
        if (b_hs) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_slot_q <= '0;
            w_slot_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            aw_slot_q <= aw_slot_d;
            w_slot_q  <= w_slot_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign bus.bvalid = bvalid_q;
    assign bus.bid    = bid_q;
    assign bus.bresp  = bresp_q;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    axi_sram_mem #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk     (aclk),
        .rst     (areset),
        .rd_en   (r_sample & ~r_err_q),
        .rd_idx  (r_idx_q),
        .rd_data (mem_rdata),
        .we      (mem_we),
        .wr_idx  (word_idx(aw_slot_q.addr)),
        .wr_data (w_slot_q.data),
        .wr_strb (w_slot_q.strb)
    );

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave against a word-array model

module tb_axi_sram_slave;
    import axi_sram_slave_pkg::*;

    localparam int          MEM_AW = 12;
    localparam logic [31:0] BASE   = 32'h1c00_0000;
    localparam int          RD_LAT = 1;
    localparam int          DEPTH  = 1 << MEM_AW;
    localparam int          TMO    = 200;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_sram_slave_if bus ();

    axi_sram_slave #(
        .MEM_AW    (MEM_AW),
        .BASE_ADDR (BASE),
        .RD_LAT    (RD_LAT)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit exp_err(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off < 0) || (off >= 4 * DEPTH) || (len != 8'd0) || (size != 3'd2);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] size, input logic [7:0] len,
                            input int aw_start, input int w_start, input int b_bp);
        bit aw_done = 0, w_done = 0, aw_now, w_now, err;
        int c = 0, lat = 0;
        err = exp_err(addr, len, size);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.wid = id; bus.wdata = data; bus.wstrb = strb; bus.wlast = 1'b1;
        while (!(aw_done && w_done) && c < TMO) begin
            bus.awvalid = !aw_done && (c >= aw_start);
            bus.wvalid  = !w_done && (c >= w_start);
            if (w_done && !aw_done) begin
                chk("w_slot_full_wready", 32'(bus.wready), 0);
                chk("w_slot_full_bvalid", 32'(bus.bvalid), 0);
            end
            if (aw_done && !w_done) begin
                chk("aw_slot_full_awready", 32'(bus.awready), 0);
                chk("aw_slot_full_bvalid", 32'(bus.bvalid), 0);
            end
            aw_now = bus.awvalid && bus.awready;
            w_now  = bus.wvalid && bus.wready;
            tick();
            aw_done |= aw_now;
            w_done  |= w_now;
            c++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("aw_w_handshake_timeout", 32'(aw_done && w_done), 1);
        while (!bus.bvalid && lat < TMO) begin
            tick();
            lat++;
        end
        chk("b_latency", lat, 1);
        chk("bid", 32'(bus.bid), 32'(id));
        chk("bresp", 32'(bus.bresp), err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
        for (int i = 0; i < b_bp; i++) begin
            tick();
            chk("b_hold_valid", 32'(bus.bvalid), 1);
            chk("b_hold_id", 32'(bus.bid), 32'(id));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("b_single", 32'(bus.bvalid), 0);
`ifndef AXI_SRAM_RAND_STALL_EN
        chk("awready_reopen", 32'(bus.awready), 1);
        chk("wready_reopen", 32'(bus.wready), 1);
`endif
        if (!err) model[widx(addr)] = merge(model.exists(widx(addr)) ? model[widx(addr)] : 32'd0,
                                            data, strb);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size,
                           input logic [7:0] len, input int bp, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        int n = 0, lat = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < TMO) begin
            tick();
            n++;
        end
        chk("ar_handshake_timeout", 32'(n < TMO), 1);
        tick();
        bus.arvalid = 1'b0;
        while (!bus.rvalid && lat < TMO) begin
            tick();
            lat++;
        end
        chk("r_latency", lat, RD_LAT);
        chk("rid", 32'(bus.rid), 32'(id));
        chk("rdata", bus.rdata, exp_data);
        chk("rresp", 32'(bus.rresp), 32'(exp_resp));
        chk("rlast", 32'(bus.rlast), 1);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("r_hold_valid", 32'(bus.rvalid), 1);
            chk("r_hold_data", bus.rdata, exp_data);
            chk("r_hold_id", 32'(bus.rid), 32'(id));
            chk("r_hold_arready", 32'(bus.arready), 0);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("r_single", 32'(bus.rvalid), 0);
`ifndef AXI_SRAM_RAND_STALL_EN
        chk("arready_after_r", 32'(bus.arready), 1);
`endif
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size,
                      input logic [7:0] len, input int bp);
        bit err;
        err = exp_err(addr, len, size);
        do_read(id, addr, size, len, bp, err ? 32'd0 : model[widx(addr)],
                err ? RESP_SLVERR : RESP_OKAY);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, e;
        logic [3:0]  s;
        logic [2:0]  sz;
        logic [7:0]  ln;
        int          idx;

        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        areset = 1'b1;
        repeat (3) tick();
        chk("rst_arready", 32'(bus.arready), 0);
        chk("rst_awready", 32'(bus.awready), 0);
        chk("rst_wready", 32'(bus.wready), 0);
        chk("rst_rvalid", 32'(bus.rvalid), 0);
        chk("rst_bvalid", 32'(bus.bvalid), 0);
        chk("rst_rid", 32'(bus.rid), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_rresp", 32'(bus.rresp), 0);
        chk("rst_rlast", 32'(bus.rlast), 0);
        chk("rst_bid", 32'(bus.bid), 0);
        chk("rst_bresp", 32'(bus.bresp), 0);
        areset = 1'b0;
        tick();

        // Give every word the random phase can touch a known value.
        for (int i = 0; i < 64; i++) begin
            idx = (i < 32) ? i : DEPTH - 64 + i;
            do_write(4'($urandom_range(0, 15)), BASE + 32'(idx * 4), $urandom, 4'hf, 3'd2, 8'd0, 0, 0, 0);
        end

        // Latency and basic data.
        do_write(LSU_ID, BASE + 32'd16, 32'hDEADBEEF, 4'hf, SIZE_WORD, 8'd0, 0, 0, 0);
        do_read(IFU_ID, BASE + 32'd16, SIZE_WORD, 8'd0, 0, 32'hDEADBEEF, RESP_OKAY);

        // Partial write.
        do_write(4'd1, BASE + 32'd32, 32'h11223344, 4'b1111, SIZE_WORD, 8'd0, 0, 0, 0);
        do_write(4'd1, BASE + 32'd32, 32'hAABBCCDD, 4'b0101, SIZE_WORD, 8'd0, 0, 0, 0);
        do_read(IFU_ID, BASE + 32'd32, SIZE_WORD, 8'd0, 0, 32'h11BB33DD, RESP_OKAY);

        // Channel ordering: W first by 3 cycles, then AW first by 3 cycles.
        do_write(LSU_ID, BASE + 32'd40, 32'hCAFE0001, 4'hf, SIZE_WORD, 8'd0, 3, 0, 0);
        do_read(LSU_ID, BASE + 32'd40, SIZE_WORD, 8'd0, 0, 32'hCAFE0001, RESP_OKAY);
        do_write(LSU_ID, BASE + 32'd44, 32'hCAFE0002, 4'hf, SIZE_WORD, 8'd0, 0, 3, 2);
        do_read(LSU_ID, BASE + 32'd44, SIZE_WORD, 8'd0, 0, 32'hCAFE0002, RESP_OKAY);

        // Read backpressure followed immediately by another read.
        do_read(4'd5, BASE + 32'd16, SIZE_WORD, 8'd0, 5, 32'hDEADBEEF, RESP_OKAY);
        do_read(4'd6, BASE + 32'd32, SIZE_WORD, 8'd0, 0, 32'h11BB33DD, RESP_OKAY);

        // Error cases at and around the window boundary.
        do_read(IFU_ID, BASE + 32'(4 * DEPTH), SIZE_WORD, 8'd0, 0, 32'd0, RESP_SLVERR);
        do_read(IFU_ID, BASE - 32'd4, SIZE_WORD, 8'd0, 0, 32'd0, RESP_SLVERR);
        rd(4'd3, BASE + 32'(4 * DEPTH - 4), SIZE_WORD, 8'd0, 0);
        do_read(4'd2, BASE + 32'd16, 3'd0, 8'd0, 0, 32'd0, RESP_SLVERR);
        do_read(4'd2, BASE + 32'd16, SIZE_WORD, 8'd1, 0, 32'd0, RESP_SLVERR);
        do_write(4'd7, BASE + 32'd16, 32'h00000000, 4'hf, 3'd0, 8'd0, 0, 0, 0);
        do_write(4'd7, BASE + 32'd16, 32'h12345678, 4'hf, SIZE_WORD, 8'd3, 0, 0, 0);
        do_write(4'd7, BASE + 32'(4 * DEPTH), 32'h12345678, 4'hf, SIZE_WORD, 8'd0, 0, 0, 0);
        do_read(IFU_ID, BASE + 32'd16, SIZE_WORD, 8'd0, 0, 32'hDEADBEEF, RESP_OKAY);

`ifndef AXI_SRAM_RAND_STALL_EN
        // Read sample and write commit land on the same edge: new bytes must win.
        e = merge(model[7], 32'h55667788, 4'b0110);
        fork
            do_write(4'd9, BASE + 32'd28, 32'h55667788, 4'b0110, SIZE_WORD, 8'd0, 0, 0, 0);
            do_read(4'd8, BASE + 32'd28, SIZE_WORD, 8'd0, 0, e, RESP_OKAY);
        join
        rd(4'd8, BASE + 32'd28, SIZE_WORD, 8'd0, 0);
`endif

        // Reset while the read is waiting on the array.
        bus.arid = 4'd4; bus.araddr = BASE + 32'd16; bus.arlen = 8'd0; bus.arsize = SIZE_WORD;
        bus.arvalid = 1'b1;
        idx = 0;
        while (!bus.arready && idx < TMO) begin
            tick();
            idx++;
        end
        tick();
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        areset = 1'b1;
        tick();
        chk("rst_mid_rvalid", 32'(bus.rvalid), 0);
        tick();
        areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_mid_no_resp", 32'(bus.rvalid), 0);
`ifndef AXI_SRAM_RAND_STALL_EN
            chk("rst_mid_arready", 32'(bus.arready), 1);
`endif
        end
        bus.rready = 1'b0;
        rd(4'd4, BASE + 32'd16, SIZE_WORD, 8'd0, 0);

        // Random traffic against the model.
        for (int it = 0; it < 1000; it++) begin
            idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31))
                                               : DEPTH - 32 + int'($urandom_range(0, 31));
            a  = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 15) == 0) a = BASE - 32'($urandom_range(1, 64) * 4);
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : SIZE_WORD;
            ln = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 15)) : 8'd0;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(4'($urandom_range(0, 15)), a, d, s, sz, ln,
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)));
            end else begin
                rd(4'($urandom_range(0, 15)), a, sz, ln, int'($urandom_range(0, 2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
